// File: rtl/biquad_cascade.sv
// biquad_cascade: N cascaded Direct Form I biquad sections that share one
// signed multiplier. Each section costs 5 MAC cycles plus one STORE cycle.
// Optional build macro BIQUAD_SATURATE_EN: clamp each section result to the
// data_width range instead of keeping the low bits (two's-complement wrap).
module biquad_cascade #(
  parameter int data_width = 16,
  parameter int n_stages   = 4,
  parameter int coef_frac  = 14,
  localparam int stage_w   = (n_stages > 1) ? $clog2(n_stages) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [data_width-1:0] sample_in,
  input  logic                         start,
  output logic                         ready,
  output logic signed [data_width-1:0] sample_out,
  output logic                         out_valid,
  input  logic signed [data_width-1:0] param_in,
  input  logic        [stage_w-1:0]    param_stage,
  input  logic        [2:0]            param_target,
  input  logic                         write_param
);

  localparam int prod_w = 2 * data_width;
  localparam int acc_w  = 2 * data_width + 3;

  typedef enum logic [1:0] {IDLE, MAC, STORE, OUT} state_t;

  state_t                        state_q, state_d;
  logic [stage_w-1:0]            stage_q, stage_d;
  logic [2:0]                    tap_q, tap_d;
  logic signed [acc_w-1:0]       acc_q, acc_d;
  logic signed [data_width-1:0]  x0_q, x0_d;
  logic signed [data_width-1:0]  sample_out_q, sample_out_d;
  logic                          out_valid_q, out_valid_d;

  // Per-section coefficients (index 0..4 = b0 b1 b2 a1 a2) and histories.
  logic signed [data_width-1:0]  coef_q [n_stages][5];
  logic signed [data_width-1:0]  coef_d [n_stages][5];
  logic signed [data_width-1:0]  x1_q [n_stages];
  logic signed [data_width-1:0]  x1_d [n_stages];
  logic signed [data_width-1:0]  x2_q [n_stages];
  logic signed [data_width-1:0]  x2_d [n_stages];
  logic signed [data_width-1:0]  y1_q [n_stages];
  logic signed [data_width-1:0]  y1_d [n_stages];
  logic signed [data_width-1:0]  y2_q [n_stages];
  logic signed [data_width-1:0]  y2_d [n_stages];

  logic signed [data_width-1:0]  mul_coef;
  logic signed [data_width-1:0]  mul_data;
  logic signed [prod_w-1:0]      prod;
  logic signed [data_width-1:0]  y_red;
  logic                          stage_ok;

  assign ready      = (state_q == IDLE);
  assign sample_out = sample_out_q;
  assign out_valid  = out_valid_q;
  assign stage_ok   = ({1'b0, param_stage} < (stage_w + 1)'(n_stages));

  // Select the coefficient/operand pair for the current tap of the current section.
  always_comb begin
    mul_coef = '0;
    mul_data = '0;
    case (tap_q)
      3'd0: begin mul_coef = coef_q[stage_q][0]; mul_data = x0_q;          end
      3'd1: begin mul_coef = coef_q[stage_q][1]; mul_data = x1_q[stage_q]; end
      3'd2: begin mul_coef = coef_q[stage_q][2]; mul_data = x2_q[stage_q]; end
      3'd3: begin mul_coef = coef_q[stage_q][3]; mul_data = y1_q[stage_q]; end
      3'd4: begin mul_coef = coef_q[stage_q][4]; mul_data = y2_q[stage_q]; end
      default: ;
    endcase
  end

  assign prod = prod_w'(mul_coef) * prod_w'(mul_data);

`ifdef BIQUAD_SATURATE_EN
  logic signed [acc_w-1:0] shifted;
  assign shifted = acc_q >>> coef_frac;

  // Clamp the scaled accumulator into the representable sample range.
  always_comb begin
    if (!shifted[acc_w-1] && (|shifted[acc_w-2:data_width-1]))
      y_red = {1'b0, {(data_width-1){1'b1}}};
    else if (shifted[acc_w-1] && !(&shifted[acc_w-2:data_width-1]))
      y_red = {1'b1, {(data_width-1){1'b0}}};
    else
      y_red = shifted[data_width-1:0];
  end
`else
  // Keep the low bits of the scaled accumulator (wraps on overflow).
  assign y_red = data_width'(acc_q >>> coef_frac);
`endif

  // Next-state, datapath and coefficient-write logic.
  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    tap_d        = tap_q;
    acc_d        = acc_q;
    x0_d         = x0_q;
    sample_out_d = sample_out_q;
    out_valid_d  = 1'b0;
    coef_d       = coef_q;
    x1_d         = x1_q;
    x2_d         = x2_q;
    y1_d         = y1_q;
    y2_d         = y2_q;

    // Writes only land while idle so a sample never sees a mixed coefficient set.
    if (state_q == IDLE && write_param && stage_ok && param_target <= 3'd4)
      coef_d[param_stage][param_target] = param_in;

    case (state_q)
      IDLE: begin
        if (start) begin
          x0_d    = sample_in;
          stage_d = '0;
          tap_d   = '0;
          acc_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        // Feedback taps (a1, a2) are subtracted.
        if (tap_q >= 3'd3) acc_d = acc_q - acc_w'(prod);
        else               acc_d = acc_q + acc_w'(prod);
        if (tap_q == 3'd4) begin
          tap_d   = '0;
          state_d = STORE;
        end else begin
          tap_d = tap_q + 3'd1;
        end
      end
      STORE: begin
        x2_d[stage_q] = x1_q[stage_q];
        x1_d[stage_q] = x0_q;
        y2_d[stage_q] = y1_q[stage_q];
        y1_d[stage_q] = y_red;
        x0_d          = y_red;
        acc_d         = '0;
        if (stage_q == stage_w'(n_stages - 1)) begin
          state_d = OUT;
        end else begin
          stage_d = stage_q + stage_w'(1);
          state_d = MAC;
        end
      end
      OUT: begin
        // x0 holds the last section's result at this point.
        sample_out_d = x0_q;
        out_valid_d  = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath, history and coefficient registers; reset clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      stage_q      <= '0;
      tap_q        <= '0;
      acc_q        <= '0;
      x0_q         <= '0;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
      for (int i = 0; i < n_stages; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
        for (int j = 0; j < 5; j++) coef_q[i][j] <= '0;
      end
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      tap_q        <= tap_d;
      acc_q        <= acc_d;
      x0_q         <= x0_d;
      sample_out_q <= sample_out_d;
      out_valid_q  <= out_valid_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      y1_q         <= y1_d;
      y2_q         <= y2_d;
      coef_q       <= coef_d;
    end
  end

endmodule

// File: tb/tb_biquad_cascade.sv
// Testbench for biquad_cascade at default parameters. Table-driven samples
// checked through a scoreboard, plus hand-written busy/reset sequences.
// Expectation for the overflow row follows BIQUAD_SATURATE_EN.
`timescale 1ns/1ps
module tb_biquad_cascade;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] sample_in;
  logic               start;
  logic               ready;
  logic signed [15:0] sample_out;
  logic               out_valid;
  logic signed [15:0] param_in;
  logic [1:0]         param_stage;
  logic [2:0]         param_target;
  logic               write_param;

  biquad_cascade dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .start        (start),
    .ready        (ready),
    .sample_out   (sample_out),
    .out_valid    (out_valid),
    .param_in     (param_in),
    .param_stage  (param_stage),
    .param_target (param_target),
    .write_param  (write_param)
  );

  always #5 clk = ~clk;

  typedef struct { int y; int t; } exp_t;
  typedef struct { bit rst; int b0; int b1; int a1; int x; int y; } vec_t;

  exp_t sb[$];
  vec_t tv[12];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ov_count = 0;
  int   sat_exp;
  int   count0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every out_valid pops one expected sample and its issue time.
  always @(negedge clk) begin : mon
    exp_t e;
    if (out_valid) begin
      ov_count++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_out_valid got=%0d want=no output", sample_out);
      end else begin
        e = sb.pop_front();
        if (int'(sample_out) != e.y || (cyc - e.t) != 25) begin
          fails++;
          $display("[TB] FAIL sample got=%0d latency=%0d want=%0d latency=25",
                   sample_out, cyc - e.t, e.y);
        end else begin
          $display("[TB] ok sample=%0d latency=%0d", sample_out, cyc - e.t);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end else begin
      $display("[TB] ok %s=%0d", name, got);
    end
  endtask

  task automatic wr(input int s, input int tgt, input int v);
    param_stage  = 2'(s);
    param_target = 3'(tgt);
    param_in     = 16'(v);
    write_param  = 1'b1;
    @(negedge clk);
    write_param  = 1'b0;
  endtask

  // Section 0 gets (b0, b1, a1); sections 1..3 are identity.
  task automatic load(input int b0, input int b1, input int a1);
    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < 5; t++) begin
        int v;
        v = (t == 0) ? 16384 : 0;
        if (s == 0 && t == 0) v = b0;
        if (s == 0 && t == 1) v = b1;
        if (s == 0 && t == 3) v = a1;
        wr(s, t, v);
      end
    end
  endtask

  task automatic send(input int x, input int y);
    exp_t e;
    e.y = y;
    e.t = cyc + 1;
    sample_in = 16'(x);
    start     = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL timeout got=%0d pending want=0 pending", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef BIQUAD_SATURATE_EN
    sat_exp = 32767;
`else
    sat_exp = -5538;
`endif
    //        rst   b0     b1     a1     x       y
    tv[0]  = '{1'b1, 16384, 0,     0,     1000,   1000};
    tv[1]  = '{1'b1, 0,     16384, 0,     1000,   0};
    tv[2]  = '{1'b0, 0,     16384, 0,     0,      1000};
    tv[3]  = '{1'b1, 16384, 0,     -8192, 1000,   1000};
    tv[4]  = '{1'b0, 16384, 0,     -8192, 0,      500};
    tv[5]  = '{1'b0, 16384, 0,     -8192, 0,      250};
    tv[6]  = '{1'b0, 16384, 0,     -8192, 0,      125};
    tv[7]  = '{1'b1, 32767, 0,     0,     30000,  sat_exp};
    tv[8]  = '{1'b1, 16384, 0,     0,     -20000, -20000};
    tv[9]  = '{1'b0, 8192,  0,     0,     -3,     -2};
    tv[10] = '{1'b0, 8192,  0,     0,     7,      3};
    tv[11] = '{1'b0, 16384, 16384, 0,     100,    107};

    reset = 1'b1; start = 1'b0; write_param = 1'b0; sample_in = '0;
    param_in = '0; param_stage = '0; param_target = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", int'(ready), 1);
    chk("reset_sample_out", int'(sample_out), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      if (tv[i].rst) do_reset();
      load(tv[i].b0, tv[i].b1, tv[i].a1);
      send(tv[i].x, tv[i].y);
      wait_idle();
    end

    // Write together with start lands first; targets 5..7 are ignored.
    do_reset();
    load(16384, 0, 0);
    param_stage = 2'd0; param_target = 3'd0; param_in = 16'sd8192; write_param = 1'b1;
    send(1000, 500);
    write_param = 1'b0;
    wait_idle();
    wr(0, 5, 0);
    wr(0, 7, 0);
    send(1000, 500);
    wait_idle();

    // Busy sample: starts at cycles 3 and 10 dropped, mid-sample write dropped.
    load(16384, 0, 0);
    count0 = ov_count;
    send(1234, 1234);
    repeat (2) @(negedge clk);
    chk("busy_ready", int'(ready), 0);
    sample_in = 16'sd999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    wr(3, 0, 0);
    repeat (2) @(negedge clk);
    sample_in = 16'sd999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("busy_out_valid_count", ov_count - count0, 1);
    send(500, 500);
    wait_idle();

    // Reset at cycle 12 of a sample abandons it and clears coefficients.
    send(1000, 1000);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_ready", int'(ready), 1);
    chk("midreset_sample_out", int'(sample_out), 0);
    chk("midreset_out_valid", int'(out_valid), 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    count0 = ov_count;
    repeat (40) @(negedge clk);
    chk("midreset_no_output", ov_count - count0, 0);
    send(1000, 0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
